// File: rtl/uart_rx_param_if.sv
// Serial-side and host-side signals of the parametrised UART receiver.
// Break_det exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 baud_tick;
   logic                 RXD;
   logic [DATA_BITS-1:0] RX_Data;
   logic                 Valid_rx;
   logic                 Parity_error;
   logic                 Stop_error;
   logic                 Busy;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                 Break_det;

   modport slave (
      input  baud_tick, RXD,
      output RX_Data, Valid_rx, Parity_error, Stop_error, Busy, Break_det
   );
   modport master (
      output baud_tick, RXD,
      input  RX_Data, Valid_rx, Parity_error, Stop_error, Busy, Break_det
   );
`else
   modport slave (
      input  baud_tick, RXD,
      output RX_Data, Valid_rx, Parity_error, Stop_error, Busy
   );
   modport master (
      output baud_tick, RXD,
      input  RX_Data, Valid_rx, Parity_error, Stop_error, Busy
   );
`endif
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority voting and false-start rejection.
// Optional break detection is enabled with the macro UART_RX_BREAK_DETECT_EN.
//
// state       | meaning
// S_IDLE      | line idle, waiting for rxd_s low on a tick
// S_START     | validating start bit; mid-bit vote of 1 aborts as a false start
// S_DATA      | sampling DATA_BITS data bits, LSB first
// S_PARITY    | sampling parity bit (PARITY_MODE != 0 only)
// S_STOP      | sampling STOP_BITS stop bits; frame completes mid last stop bit
// S_WAIT_HIGH | after a break, waiting for the line to return high
module uart_rx_param #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1
) (
   input logic clk,
   input logic reset,
   uart_rx_param_if.slave bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] M_LO   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] M_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] M_HI   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
   localparam logic          S_LAST = 1'(STOP_BITS - 1);
   localparam logic          ODD    = (PARITY_MODE == 2);
   localparam logic          HAS_PAR = (PARITY_MODE != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
      , S_WAIT_HIGH
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_pend_q, perr_pend_d;
   logic                 serr_pend_q, serr_pend_d;
   logic                 seen_high_q, seen_high_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 parity_error_q, parity_error_d;
   logic                 stop_error_q, stop_error_d;
   logic                 valid_q, valid_d;
   logic                 rxd_meta_q, rxd_meta_d;
   logic                 rxd_s_q, rxd_s_d;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                 break_q, break_d;
   logic                 brk_now;
`endif

   logic          vote;
   logic [TW-1:0] tcnt_nxt;
   logic          serr_now;

   // Third sample is the live synchronised line at tcnt = M+1.
   assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);
   assign tcnt_nxt = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
   assign serr_now = serr_pend_q | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
   // Every vote in the frame (data, parity, stop) was low.
   assign brk_now  = ~seen_high_q & ~vote;
`endif

   always_comb begin
      state_d        = state_q;
      tcnt_d         = tcnt_q;
      idx_d          = idx_q;
      stop_cnt_d     = stop_cnt_q;
      samp_d         = samp_q;
      shift_d        = shift_q;
      perr_pend_d    = perr_pend_q;
      serr_pend_d    = serr_pend_q;
      seen_high_d    = seen_high_q;
      rx_data_d      = rx_data_q;
      parity_error_d = parity_error_q;
      stop_error_d   = stop_error_q;
      valid_d        = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_d        = 1'b0;
`endif
      rxd_meta_d     = bus.RXD;
      rxd_s_d        = rxd_meta_q;

      if (bus.baud_tick) begin
         if (tcnt_q == M_LO)  samp_d[0] = rxd_s_q;
         if (tcnt_q == M_MID) samp_d[1] = rxd_s_q;

         case (state_q)
            S_IDLE: begin
               tcnt_d = '0;
               if (!rxd_s_q) begin
                  state_d     = S_START;
                  tcnt_d      = TW'(1);
                  idx_d       = '0;
                  stop_cnt_d  = 1'b0;
                  perr_pend_d = 1'b0;
                  serr_pend_d = 1'b0;
                  seen_high_d = 1'b0;
               end
            end

            S_START: begin
               tcnt_d = tcnt_nxt;
               if ((tcnt_q == M_HI) && vote) begin
                  state_d = S_IDLE;
                  tcnt_d  = '0;
               end else if (tcnt_q == T_LAST) begin
                  state_d = S_DATA;
               end
            end

            S_DATA: begin
               tcnt_d = tcnt_nxt;
               if (tcnt_q == M_HI) begin
                  shift_d[idx_q] = vote;
                  seen_high_d    = seen_high_q | vote;
               end
               if (tcnt_q == T_LAST) begin
                  if (idx_q == I_LAST) begin
                     state_d = HAS_PAR ? S_PARITY : S_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end

            S_PARITY: begin
               tcnt_d = tcnt_nxt;
               if (tcnt_q == M_HI) begin
                  perr_pend_d = (^shift_q) ^ vote ^ ODD;
                  seen_high_d = seen_high_q | vote;
               end
               if (tcnt_q == T_LAST) state_d = S_STOP;
            end

            S_STOP: begin
               tcnt_d = tcnt_nxt;
               if (tcnt_q == M_HI) begin
                  serr_pend_d = serr_now;
                  seen_high_d = seen_high_q | vote;
                  if (stop_cnt_q == S_LAST) begin
                     state_d = S_IDLE;
                     tcnt_d  = '0;
`ifdef UART_RX_BREAK_DETECT_EN
                     if (brk_now) begin
                        state_d = S_WAIT_HIGH;
                        break_d = 1'b1;
                     end else begin
                        rx_data_d      = shift_q;
                        parity_error_d = HAS_PAR & perr_pend_q;
                        stop_error_d   = serr_now;
                        valid_d        = 1'b1;
                     end
`else
                     rx_data_d      = shift_q;
                     parity_error_d = HAS_PAR & perr_pend_q;
                     stop_error_d   = serr_now;
                     valid_d        = 1'b1;
`endif
                  end
               end else if (tcnt_q == T_LAST) begin
                  stop_cnt_d = 1'b1;
               end
            end

`ifdef UART_RX_BREAK_DETECT_EN
            S_WAIT_HIGH: begin
               tcnt_d = '0;
               if (rxd_s_q) state_d = S_IDLE;
            end
`endif

            default: begin
               state_d = S_IDLE;
               tcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         tcnt_q         <= '0;
         idx_q          <= '0;
         stop_cnt_q     <= 1'b0;
         samp_q         <= 2'b11;
         shift_q        <= '0;
         perr_pend_q    <= 1'b0;
         serr_pend_q    <= 1'b0;
         seen_high_q    <= 1'b0;
         rx_data_q      <= '0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
         valid_q        <= 1'b0;
         rxd_meta_q     <= 1'b1;
         rxd_s_q        <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
         break_q        <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         tcnt_q         <= tcnt_d;
         idx_q          <= idx_d;
         stop_cnt_q     <= stop_cnt_d;
         samp_q         <= samp_d;
         shift_q        <= shift_d;
         perr_pend_q    <= perr_pend_d;
         serr_pend_q    <= serr_pend_d;
         seen_high_q    <= seen_high_d;
         rx_data_q      <= rx_data_d;
         parity_error_q <= parity_error_d;
         stop_error_q   <= stop_error_d;
         valid_q        <= valid_d;
         rxd_meta_q     <= rxd_meta_d;
         rxd_s_q        <= rxd_s_d;
`ifdef UART_RX_BREAK_DETECT_EN
         break_q        <= break_d;
`endif
      end
   end

   assign bus.RX_Data      = rx_data_q;
   assign bus.Valid_rx     = valid_q;
   assign bus.Parity_error = parity_error_q;
   assign bus.Stop_error   = stop_error_q;
   assign bus.Busy         = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
   assign bus.Break_det    = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default 8E1 instance at one tick per clk,
// plus a 7O2 instance ticking every 4th clk. Break test runs when UART_RX_BREAK_DETECT_EN is defined.
module tb_uart_rx_param;

   localparam int CPB0 = 16;
   localparam int CPB1 = 64;

   typedef struct packed {
      logic       perr;
      logic       serr;
      logic [7:0] data;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) ifc0 ();
   uart_rx_param_if #(.DATA_BITS(7)) ifc1 ();

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .bus(ifc0.slave));
   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
      .clk(clk), .reset(reset), .bus(ifc1.slave));

   int checks = 0;
   int errors = 0;
   int valid0_cnt = 0;
   int valid1_cnt = 0;
   int brk_cnt = 0;
   int tdiv = 0;
   rec_t exp0[$];
   rec_t exp1[$];
   rec_t obs0[$];
   rec_t obs1[$];

   always @(posedge clk) begin
      #1;
      tdiv = (tdiv + 1) % 4;
      ifc1.baud_tick = (tdiv == 0);
   end

   always @(negedge clk) begin
      if (ifc0.Valid_rx === 1'b1) begin
         obs0.push_back({ifc0.Parity_error, ifc0.Stop_error, ifc0.RX_Data});
         valid0_cnt++;
      end
      if (ifc1.Valid_rx === 1'b1) begin
         obs1.push_back({ifc1.Parity_error, ifc1.Stop_error, 1'b0, ifc1.RX_Data});
         valid1_cnt++;
      end
`ifdef UART_RX_BREAK_DETECT_EN
      if (ifc0.Break_det === 1'b1) brk_cnt++;
`endif
   end

   function automatic rec_t mk(input logic [7:0] d, input logic p, input logic s);
      return {p, s, d};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Default instance frame: start, 8 data LSB first, even parity (optionally corrupted), stop.
   task automatic send0(input logic [7:0] d, input logic bad_par, input logic stp);
      logic [10:0] bits;
      bits = {stp, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ifc0.RXD = bits[i];
         step(CPB0);
      end
      ifc0.RXD = 1'b1;
   endtask

   // 7O2 instance frame: start, 7 data, odd parity, two stop bits.
   task automatic send1(input logic [6:0] d, input logic s1, input logic s2);
      logic [10:0] bits;
      bits = {s2, s1, ~(^d), d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ifc1.RXD = bits[i];
         step(CPB1);
      end
      ifc1.RXD = 1'b1;
   endtask

   task automatic get0(output rec_t r, output bit ok);
      ok = 1'b0;
      r  = '0;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (obs0.size() > 0) begin
            r  = obs0.pop_front();
            ok = 1'b1;
         end else begin
            step(1);
         end
      end
   endtask

   task automatic get1(output rec_t r, output bit ok);
      ok = 1'b0;
      r  = '0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         if (obs1.size() > 0) begin
            r  = obs1.pop_front();
            ok = 1'b1;
         end else begin
            step(1);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifc0.RXD = 1'b1;
      ifc1.RXD = 1'b1;
      step(5);
      checks++;
      if (ifc0.RX_Data !== 8'h00) begin
         errors++; $display("FAIL reset_rx_data got %h exp 00", ifc0.RX_Data);
      end
      checks++;
      if ({ifc0.Valid_rx, ifc0.Parity_error, ifc0.Stop_error, ifc0.Busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000",
                  {ifc0.Valid_rx, ifc0.Parity_error, ifc0.Stop_error, ifc0.Busy});
      end
      checks++;
      if ({ifc1.RX_Data, ifc1.Busy} !== 8'h00) begin
         errors++; $display("FAIL reset_u1 got %h exp 00", {ifc1.RX_Data, ifc1.Busy});
      end
      reset = 1'b0;
      step(4);
   endtask

   task automatic test_clean_frame();
      rec_t o, e;
      bit   ok;
      int   v;
      v = valid0_cnt;
      exp0.push_back(mk(8'hA5, 1'b0, 1'b0));
      send0(8'hA5, 1'b0, 1'b1);
      get0(o, ok);
      e = exp0.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++; $display("FAIL clean_a5 got %h exp %h timeout %0d", o, e, !ok);
      end
      step(4);
      checks++;
      if (valid0_cnt !== v + 1) begin
         errors++; $display("FAIL clean_one_pulse got %0d exp %0d", valid0_cnt - v, 1);
      end
      checks++;
      if (ifc0.Busy !== 1'b0) begin
         errors++; $display("FAIL clean_busy_after got %b exp 0", ifc0.Busy);
      end
   endtask

   task automatic test_parity_error();
      rec_t o, e;
      bit   ok;
      exp0.push_back(mk(8'h3C, 1'b1, 1'b0));
      send0(8'h3C, 1'b1, 1'b1);
      exp0.push_back(mk(8'h01, 1'b0, 1'b0));
      send0(8'h01, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         get0(o, ok);
         e = exp0.pop_front();
         checks++;
         if (!ok || o !== e) begin
            errors++; $display("FAIL parity_frame%0d got %h exp %h timeout %0d", k, o, e, !ok);
         end
      end
   endtask

   task automatic test_false_start();
      int v;
      v = valid0_cnt;
      ifc0.RXD = 1'b0;
      step(2);
      ifc0.RXD = 1'b1;
      step(4);
      checks++;
      if (ifc0.Busy !== 1'b1) begin
         errors++; $display("FAIL glitch_busy_during got %b exp 1", ifc0.Busy);
      end
      step(20);
      checks++;
      if (ifc0.Busy !== 1'b0) begin
         errors++; $display("FAIL glitch_busy_after got %b exp 0", ifc0.Busy);
      end
      checks++;
      if (valid0_cnt !== v) begin
         errors++; $display("FAIL glitch_no_valid got %0d exp 0", valid0_cnt - v);
      end
   endtask

   task automatic test_7o2_stop_error();
      rec_t o, e;
      bit   ok;
      int   v;
      v = valid1_cnt;
      exp1.push_back(mk(8'h2A, 1'b0, 1'b0));
      send1(7'h2A, 1'b1, 1'b1);
      exp1.push_back(mk(8'h55, 1'b0, 1'b1));
      send1(7'h55, 1'b1, 1'b0);
      step(CPB1 * 2);
      for (int k = 0; k < 2; k++) begin
         get1(o, ok);
         e = exp1.pop_front();
         checks++;
         if (!ok || o !== e) begin
            errors++; $display("FAIL u1_frame%0d got %h exp %h timeout %0d", k, o, e, !ok);
         end
      end
      checks++;
      if (valid1_cnt !== v + 2) begin
         errors++; $display("FAIL u1_pulse_count got %0d exp 2", valid1_cnt - v);
      end
      checks++;
      if (ifc1.Busy !== 1'b0) begin
         errors++; $display("FAIL u1_busy_after got %b exp 0", ifc1.Busy);
      end
   endtask

   task automatic test_back_to_back();
      rec_t o, e;
      bit   ok;
      int   v;
      v = valid0_cnt;
      exp0.push_back(mk(8'h00, 1'b0, 1'b0));
      exp0.push_back(mk(8'hFF, 1'b0, 1'b0));
      send0(8'h00, 1'b0, 1'b1);
      send0(8'hFF, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         get0(o, ok);
         e = exp0.pop_front();
         checks++;
         if (!ok || o !== e) begin
            errors++; $display("FAIL b2b_frame%0d got %h exp %h timeout %0d", k, o, e, !ok);
         end
      end
      step(4);
      checks++;
      if (valid0_cnt !== v + 2) begin
         errors++; $display("FAIL b2b_pulse_count got %0d exp 2", valid0_cnt - v);
      end
   endtask

   task automatic test_reset_mid_frame();
      rec_t o, e;
      bit   ok;
      int   v;
      v = valid0_cnt;
      ifc0.RXD = 1'b0;
      step(CPB0);
      ifc0.RXD = 1'b1;
      step(CPB0);
      ifc0.RXD = 1'b0;
      step(CPB0 * 2);
      checks++;
      if (ifc0.Busy !== 1'b1) begin
         errors++; $display("FAIL midreset_busy_before got %b exp 1", ifc0.Busy);
      end
      reset = 1'b1;
      step(2);
      checks++;
      if ({ifc0.RX_Data, ifc0.Busy} !== 9'h000) begin
         errors++; $display("FAIL midreset_cleared got %h exp 000", {ifc0.RX_Data, ifc0.Busy});
      end
      ifc0.RXD = 1'b1;
      reset = 1'b0;
      step(CPB0 * 2);
      exp0.push_back(mk(8'h42, 1'b0, 1'b0));
      send0(8'h42, 1'b0, 1'b1);
      get0(o, ok);
      e = exp0.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++; $display("FAIL midreset_42 got %h exp %h timeout %0d", o, e, !ok);
      end
      step(4);
      checks++;
      if (valid0_cnt !== v + 1) begin
         errors++; $display("FAIL midreset_pulse_count got %0d exp 1", valid0_cnt - v);
      end
   endtask

`ifdef UART_RX_BREAK_DETECT_EN
   task automatic test_break();
      int v, b;
      v = valid0_cnt;
      b = brk_cnt;
      ifc0.RXD = 1'b0;
      step(CPB0 * 20);
      checks++;
      if (ifc0.Busy !== 1'b1) begin
         errors++; $display("FAIL break_busy_low got %b exp 1", ifc0.Busy);
      end
      ifc0.RXD = 1'b1;
      step(8);
      checks++;
      if (ifc0.Busy !== 1'b0) begin
         errors++; $display("FAIL break_busy_high got %b exp 0", ifc0.Busy);
      end
      checks++;
      if (brk_cnt !== b + 1 || valid0_cnt !== v) begin
         errors++;
         $display("FAIL break_pulses got brk %0d valid %0d exp brk 1 valid 0",
                  brk_cnt - b, valid0_cnt - v);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      ifc0.RXD = 1'b1;
      ifc1.RXD = 1'b1;
      ifc0.baud_tick = 1'b1;
      ifc1.baud_tick = 1'b0;
      test_reset();
      test_clean_frame();
      test_parity_error();
      test_false_start();
      test_7o2_stop_error();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_RX_BREAK_DETECT_EN
      test_break();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
